// File: rtl/spad_rd_arbiter.sv
// Burst-limited round-robin arbiter sharing one 1R scratchpad read port among NREQ
// requesters; read data is returned tagged by a registered rvalid one cycle after the grant.
module spad_rd_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 en_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      rvalid_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 csb1_o,
    output logic [AW-1:0]        addr1_o,
    input  logic [DW-1:0]        dout1_i,
    output logic                 busy_o
);

    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   r_rr_ptr;
    logic [BW-1:0]   r_burst_cnt;
    logic [NREQ-1:0] r_rvalid;

    logic [NREQ-1:0] w_owner_oh;
    logic [NREQ-1:0] w_others;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_scan_idx;
    logic [PW-1:0]   w_gnt_idx;
    logic [AW-1:0]   w_addr;
    logic            w_at_limit;
    logic            w_keep;
    logic            w_gnt_any;
    int              w_off;
    int              w_sum;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_owner_oh = NREQ'(1) << r_owner;
        w_at_limit = (r_burst_cnt >= MAX_B);
        w_others   = req_i & ~w_owner_oh;
        w_keep     = (|(req_i & w_owner_oh)) && (!w_at_limit || !(|w_others));

        // A capped owner is taken out of the round-robin scan.
        w_cand = w_at_limit ? w_others : req_i;
        w_rot  = NREQ'({w_cand, w_cand} >> r_rr_ptr);
        w_off  = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = i;
        end
        w_sum = int'(r_rr_ptr) + w_off;
        if (w_sum >= NREQ) w_sum = w_sum - NREQ;
        w_scan_idx = PW'(w_sum);

        w_gnt_idx = w_keep ? r_owner : w_scan_idx;
        // Reset gates the grant directly so the SRAM is deselected while n_rst is low.
        w_gnt_any = n_rst && en_i && (|req_i);
        w_gnt     = w_gnt_any ? (NREQ'(1) << w_gnt_idx) : '0;

        w_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt[k]) w_addr = addr_i[k*AW +: AW];
        end
    end

    // NOTE: state registers use non-blocking assignments and the async active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rvalid    <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt_any) begin
                r_rr_ptr <= (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;
                if (w_gnt_idx == r_owner) begin
                    r_burst_cnt <= w_at_limit ? BW'(1) : r_burst_cnt + 1'b1;
                end else begin
                    r_owner     <= w_gnt_idx;
                    r_burst_cnt <= BW'(1);
                end
            end else if (en_i && !(|req_i)) begin
                r_burst_cnt <= '0;
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = dout1_i;
    assign csb1_o   = ~(|w_gnt);
    assign addr1_o  = w_addr;
    assign busy_o   = (|w_gnt) || (|r_rvalid);

endmodule

// File: tb/tb_spad_rd_arbiter.sv
// Scoreboard bench for spad_rd_arbiter: a reference arbiter predicts each grant, the
// expected read return is queued, and an independent monitor matches it against rvalid/rdata.
module tb_spad_rd_arbiter;

    localparam int NREQ      = 3;
    localparam int AW        = 6;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 en_i;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*AW-1:0]   addr_i;
    logic [NREQ-1:0]      gnt_o;
    logic [NREQ-1:0]      rvalid_o;
    logic [DW-1:0]        rdata_o;
    logic                 csb1_o;
    logic [AW-1:0]        addr1_o;
    logic [DW-1:0]        dout1_i;
    logic                 busy_o;

    spad_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .n_rst(n_rst), .en_i(en_i), .req_i(req_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .csb1_o(csb1_o),
        .addr1_o(addr1_o), .dout1_i(dout1_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // 1-cycle-latency SRAM read port, preloaded with mem[i] = 0x1000 + i.
    logic [DW-1:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    initial dout1_i = '0;
    always @(posedge clk) if (!csb1_o) dout1_i <= mem[addr1_o];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   glog[$];
    logic [NREQ-1:0] rvlog[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Requester state and arbitration reference.
    int left     [NREQ];
    int cur_addr [NREQ];
    bit rand_mode = 1'b0;
    bit en_cmd    = 1'b1;
    bit last_gnt  = 1'b0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_ptr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [NREQ-1:0] req);
        bit capped = (m_cnt >= MAX_BURST);
        bit rivals = (req & ~(NREQ'(1) << m_owner)) != '0;
        if (req[m_owner] && (!capped || !rivals)) return m_owner;
        for (int i = 0; i < NREQ; i++) begin
            int c = (m_ptr + i) % NREQ;
            if (req[c] && !(c == m_owner && capped)) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        en_i = en_cmd;
        for (int k = 0; k < NREQ; k++) begin
            req_i[k] = (left[k] > 0);
            addr_i[k*AW +: AW] = AW'(cur_addr[k]);
        end
    endtask

    task automatic check_cycle();
        int idx;
        int act;
        logic [NREQ-1:0] eg;
        idx = (en_i && req_i != '0) ? ref_pick(req_i) : -1;
        eg  = (idx >= 0) ? (NREQ'(1) << idx) : '0;
        check("gnt", 32'(gnt_o), 32'(eg));
        check("csb1", 32'(csb1_o), 32'(idx < 0));
        check("addr1", 32'(addr1_o), (idx >= 0) ? 32'(cur_addr[idx]) : 32'd0);
        check("busy", 32'(busy_o), 32'((eg != '0) || last_gnt));
        act = -1;
        for (int k = 0; k < NREQ; k++) if (gnt_o[k]) act = k;
        glog.push_back(act);
        rvlog.push_back(rvalid_o);
        last_gnt = (eg != '0);
        if (idx >= 0) begin
            sb.push_back('{cyc + 1, idx, 32'h1000 + cur_addr[idx]});
            if (idx == m_owner) m_cnt = (m_cnt >= MAX_BURST) ? 1 : m_cnt + 1;
            else begin
                m_owner = idx;
                m_cnt   = 1;
            end
            m_ptr = (idx + 1) % NREQ;
            left[idx]--;
            cur_addr[idx] = rand_mode ? int'($urandom_range(0, 63)) : (cur_addr[idx] + 1) % 64;
        end else if (en_i && req_i == '0) begin
            m_cnt = 0;
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            en_cmd = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (left[k] == 0 && $urandom_range(0, 3) == 0) begin
                    left[k]     = $urandom_range(1, 8);
                    cur_addr[k] = $urandom_range(0, 63);
                end
            end
        end
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    // Asserts reset mid-cycle, checks the reset-state outputs, releases and runs the first cycle.
    task automatic apply_reset();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        sb.delete();
        m_owner  = 0;
        m_cnt    = 0;
        m_ptr    = 0;
        last_gnt = 1'b0;
        drive();
        @(negedge clk);
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_csb1", 32'(csb1_o), 32'd1);
        check("rst_addr1", 32'(addr1_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        drive();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        int total;
        forever begin
            total = 0;
            for (int k = 0; k < NREQ; k++) total += left[k];
            if (total == 0 || n >= budget) break;
            do_cycle();
            n++;
        end
        check("drain_budget_left", 32'(total), 32'd0);
        repeat (2) do_cycle();
    endtask

    task automatic start(input int l0, input int a0, input int l1, input int a1);
        for (int k = 0; k < NREQ; k++) begin
            left[k]     = 0;
            cur_addr[k] = 0;
        end
        left[0] = l0; cur_addr[0] = a0;
        left[1] = l1; cur_addr[1] = a1;
        en_cmd = 1'b1;
        glog.delete();
        rvlog.delete();
    endtask

    // Monitor: onehot properties, rvalid tracks the previous grant, scoreboard match.
    initial begin : monitor
        exp_t e;
        logic [NREQ-1:0] prev_gnt;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
            check("rvalid_onehot0", 32'($onehot0(rvalid_o)), 32'd1);
            if (n_rst) check("rvalid_follows_gnt", 32'(rvalid_o), 32'(prev_gnt));
            else       check("rvalid_in_reset", 32'(rvalid_o), 32'd0);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("rvalid_tag", 32'(rvalid_o), 32'(NREQ'(1) << e.idx));
                check("rdata", rdata_o, e.data);
            end else begin
                check("rvalid_idle", 32'(rvalid_o), 32'd0);
            end
            prev_gnt = n_rst ? gnt_o : '0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        n_rst  = 1'b1;
        en_i   = 1'b0;
        req_i  = '0;
        addr_i = '0;
        for (int k = 0; k < NREQ; k++) begin
            left[k]     = 0;
            cur_addr[k] = 0;
        end
        #1 n_rst = 1'b0;

        // Single requester, addresses 8..11.
        start(4, 8, 0, 0);
        apply_reset();
        drain(50);
        for (int i = 0; i < 4; i++) check("single_gnt", 32'(glog[i]), 32'd0);
        check("single_idle_after", 32'(glog[4]), 32'hffff_ffff);

        // Contention from reset: 4-grant bursts alternating with no idle cycle.
        start(12, 0, 12, 32);
        apply_reset();
        drain(100);
        for (int i = 0; i < 24; i++) check("contention_gnt", 32'(glog[i]), 32'((i / 4) % 2));

        // Burst limit without a competitor does not stall.
        start(0, 0, 10, 30);
        apply_reset();
        drain(50);
        for (int i = 0; i < 10; i++) check("solo_burst_gnt", 32'(glog[i]), 32'd1);

        // en_i gating: 2 grants, 3-cycle pause, resume with the same owner.
        start(4, 16, 2, 48);
        apply_reset();
        do_cycle();
        en_cmd = 1'b0;
        repeat (3) do_cycle();
        en_cmd = 1'b1;
        drain(50);
        check("en_pause_gnt0", 32'(glog[2]), 32'hffff_ffff);
        check("en_pause_gnt2", 32'(glog[4]), 32'hffff_ffff);
        check("en_owed_rvalid", 32'(rvlog[2]), 32'd1);
        check("en_no_stale_rvalid", 32'(rvlog[3]), 32'd0);
        check("en_resume_owner", 32'(glog[5]), 32'd0);
        check("en_then_rival", 32'(glog[7]), 32'd1);

        // Owner drops after 2 reads while requester 1 waits: no bubble.
        start(2, 4, 3, 60);
        apply_reset();
        drain(50);
        check("drop_gnt1", 32'(glog[1]), 32'd0);
        check("drop_handover", 32'(glog[2]), 32'd1);

        // Reset in the cycle after a grant discards the owed read.
        start(6, 20, 6, 40);
        apply_reset();
        check("midrst_first", 32'(glog[0]), 32'd0);
        glog.delete();
        apply_reset();
        check("midrst_after_release", 32'(glog[0]), 32'd0);
        drain(100);

        // Randomized traffic with random en_i against the reference arbiter.
        rand_mode = 1'b1;
        repeat (800) do_cycle();
        rand_mode = 1'b0;
        en_cmd    = 1'b1;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
